imem_fetch_ctrl: RTL and testbench
==================================

# imem_fetch_ctrl

Sequencing controller for the byte-addressed, little-endian instruction memory. After reset it boot-loads the memory from an 8-bit valid/ready byte stream through the memory's byte write port. It then hands the memory to the core by running the fetch PC (sequential +4, stall, branch redirect). It bounds-checks every fetch address against the loaded image and reports completion or fault.

## Interface
Parameters:
- MEM_BYTES, 36: instruction memory size in bytes; multiple of 4.
- RESET_PC, 0: first fetch address after load; word aligned.
- AW, 32: PC / memory address width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-low
- ld_valid  in  1  loader byte valid
- ld_data  in  8  loader byte; byte k of the stream goes to address k
- ld_last  in  1  marks final byte of image, qualified by ld_valid
- ld_ready  out  1  controller accepts a loader byte
- mem_we  out  1  byte write strobe to instruction memory
- mem_waddr  out  AW  byte write address
- mem_wdata  out  8  byte write data
- pc  out  AW  fetch address driven to the memory read port
- fetch_valid  out  1  pc points to a valid instruction this cycle
- stall  in  1  hold pc; ignored outside RUN
- redir_valid  in  1  branch/jump redirect
- redir_pc  in  AW  redirect target
- done  out  1  sequential fetch ran off the end of the image
- fault  out  1  load or redirect error, sticky until reset

## Operation
- States: LOAD, LFLUSH, RUN, DONE, FAULT. The encoding is in the package.
- Reset (reset==0 at a clock edge) forces:
  - state=LOAD, ld_ready=1, mem_we=0, mem_waddr=0, mem_wdata=0
  - pc=RESET_PC, fetch_valid=0, done=0, fault=0
  - byte count cnt=0
  - Reset applied mid-load or mid-run aborts the operation identically. Memory contents are not cleared.
- LOAD: ld_ready=1.
  - A byte is accepted on ld_valid&&ld_ready.
  - The next cycle registers mem_we=1, mem_waddr=cnt, mem_wdata=byte. cnt increments.
  - Load ends on acceptance of a byte with ld_last=1, or on acceptance of byte MEM_BYTES-1 (implicit last). Either ends in LFLUSH, with ld_ready=0 from the next cycle.
- LFLUSH: the final write occurs this cycle. Final cnt is then checked:
  - cnt==0, cnt%4!=0, or RESET_PC+4>cnt → FAULT.
  - Otherwise → RUN. limit=cnt is latched.
- RUN: fetch_valid=1. Next-pc priority per cycle:
  1. redir_valid: redir_pc[1:0]!=0 or redir_pc+4>limit → FAULT. Otherwise pc=redir_pc.
  2. stall: pc held.
  3. Otherwise: pc+4>=limit → DONE with pc held. Otherwise pc=pc+4.
- DONE: fetch_valid=0, done=1, pc frozen. Inputs are ignored until reset.
- FAULT: fetch_valid=0, fault=1, ld_ready=0, mem_we=0. Inputs are ignored until reset.
- Arithmetic: pc+4 and redir_pc+4 are computed at AW+1 bits so wrap at 2^AW reads as out of range. cnt is clog2(MEM_BYTES)+1 bits.

## Timing
- Loader handshake: a byte transfers in any cycle with valid&&ready. The source may hold valid with ready low.
- Write latency is 1 cycle from acceptance to mem_we. There is at most one write per cycle.
- Back-to-back bytes sustain 1 byte/cycle.
- First fetch: the last byte is accepted in cycle n, writes in n+1 (LFLUSH), and RUN starts in n+2 with fetch_valid=1 and pc=RESET_PC.
- All outputs are registered, except ld_ready and fetch_valid, which are decoded directly from state.
- A redirect or +4 takes effect on pc in the cycle after it is sampled.
- A redirect in the same cycle as stall wins.
- Redirect and stall are ignored in LOAD and LFLUSH.

## Structure
- Package imem_ctrl_pkg holds:
  - state enum
  - INSTR_BYTES=4 constant
  - function in_range(addr, limit), returning (addr+4<=limit)&&(addr[1:0]==0)
- The load write-pointer/counter is a natural sub-module, imem_load_counter: accept, cnt, last, saturate at MEM_BYTES.
- The remainder is a single FSM plus the PC register.

## Test plan
- Load 16 bytes 33 83 49 01 33 84 20 40 b3 03 53 02 93 00 21 00 with ld_last on byte 15 →
  - 16 writes, addresses 0..15, in order
  - RUN 2 cycles after the last accept
  - pc sequence 0, 4, 8, 12, then DONE with pc=12 and done=1
- Same load with ld_valid toggling every other cycle → identical memory image and write order. No byte is dropped or duplicated.
- Load 6 bytes with ld_last → fault=1 after LFLUSH, fetch_valid never 1.
- RUN, pc=4: stall for 3 cycles → pc stays 4. Then redir_valid with redir_pc=0 alongside stall → pc=0 next cycle.
- RUN, limit=16: redirect to 16 → FAULT. Separately, redirect to 6 → FAULT. Redirect to 12 → pc=12, then DONE.
- Load 36 bytes without ld_last → implicit end after byte 35 and ld_ready=0. Assert reset mid-RUN → all outputs at reset values and state LOAD.

Source files
------------

// File: rtl/imem_ctrl_pkg.sv
// rtl/imem_ctrl_pkg.sv - shared types, constants and range helper for the instruction-memory fetch controller
package imem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_LFLUSH = 3'd1,
        ST_RUN    = 3'd2,
        ST_DONE   = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    localparam int unsigned INSTR_BYTES = 4;

    // Operands are widened to 64 bits so the +4 never wraps for any AW below 64;
    // an address whose word would cross 2^AW therefore lands out of range.
    function automatic logic in_range(input logic [63:0] addr, input logic [63:0] limit);
        logic [64:0] end_addr;
        end_addr = {1'b0, addr} + 65'(INSTR_BYTES);
        return (end_addr <= {1'b0, limit}) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/imem_load_counter.sv
// rtl/imem_load_counter.sv - boot-load byte counter with explicit and implicit end-of-image detect
module imem_load_counter
    import imem_ctrl_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 36,
    parameter int unsigned CW        = $clog2(MEM_BYTES) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          accept,
    input  logic          last_in,
    output logic [CW-1:0] cnt,
    output logic          last
);

    // The image ends on a flagged byte or when the byte filling the memory is taken.
    assign last = accept && (last_in || (cnt == CW'(MEM_BYTES - 1)));

    // Count accepted bytes, saturating at the memory size.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (accept && (cnt != CW'(MEM_BYTES))) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - boot-loads instruction memory then sequences the fetch PC with bounds checking
module imem_fetch_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 36,
    parameter int unsigned RESET_PC  = 0,
    parameter int unsigned AW        = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [7:0]    mem_wdata,
    output logic [AW-1:0] pc,
    output logic          fetch_valid,
    input  logic          stall,
    input  logic          redir_valid,
    input  logic [AW-1:0] redir_pc,
    output logic          done,
    output logic          fault
);

    localparam int unsigned CW = $clog2(MEM_BYTES) + 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] limit;
    logic          accept;
    logic          load_end;
    logic [AW:0]   pc_next4;
    logic [AW:0]   limit_ext;
    logic          redir_ok;
    logic          image_ok;

    assign ld_ready    = (state == ST_LOAD);
    assign fetch_valid = (state == ST_RUN);
    assign accept      = ld_valid && ld_ready;

    imem_load_counter #(
        .MEM_BYTES (MEM_BYTES),
        .CW        (CW)
    ) u_load_counter (
        .clk     (clk),
        .reset   (reset),
        .accept  (accept),
        .last_in (ld_last),
        .cnt     (cnt),
        .last    (load_end)
    );

    assign pc_next4  = {1'b0, pc} + (AW + 1)'(INSTR_BYTES);
    assign limit_ext = (AW + 1)'(limit);
    assign redir_ok  = in_range(64'(redir_pc), 64'(limit));
    // An image must be non-empty, whole words, and hold at least the first instruction.
    assign image_ok  = (cnt != '0) && (cnt[1:0] == 2'b00) &&
                       in_range(64'(RESET_PC), 64'(cnt));

    // Load/flush/run sequencer with registered memory-write, pc and status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_LOAD;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            pc        <= AW'(RESET_PC);
            done      <= 1'b0;
            fault     <= 1'b0;
            limit     <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    mem_we <= accept;
                    if (accept) begin
                        mem_waddr <= AW'(cnt);
                        mem_wdata <= ld_data;
                    end
                    if (load_end) begin
                        state <= ST_LFLUSH;
                    end
                end
                ST_LFLUSH: begin
                    mem_we <= 1'b0;
                    if (image_ok) begin
                        limit <= cnt;
                        state <= ST_RUN;
                    end else begin
                        fault <= 1'b1;
                        state <= ST_FAULT;
                    end
                end
                ST_RUN: begin
                    if (redir_valid) begin
                        if (redir_ok) begin
                            pc <= redir_pc;
                        end else begin
                            fault <= 1'b1;
                            state <= ST_FAULT;
                        end
                    end else if (!stall) begin
                        if (pc_next4 >= limit_ext) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            pc <= pc_next4[AW-1:0];
                        end
                    end
                end
                ST_DONE: begin
                end
                ST_FAULT: begin
                    mem_we <= 1'b0;
                end
                default: begin
                    mem_we <= 1'b0;
                    fault  <= 1'b1;
                    state  <= ST_FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb/tb_imem_fetch_ctrl.sv - scoreboard bench for the instruction-memory load and fetch controller
module tb_imem_fetch_ctrl;

    localparam int unsigned MEM_BYTES = 36;
    localparam int unsigned RESET_PC  = 0;
    localparam int unsigned AW        = 32;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ld_valid = 1'b0;
    logic [7:0]    ld_data = 8'h00;
    logic          ld_last = 1'b0;
    logic          ld_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic [AW-1:0] pc;
    logic          fetch_valid;
    logic          stall = 1'b0;
    logic          redir_valid = 1'b0;
    logic [AW-1:0] redir_pc = '0;
    logic          done;
    logic          fault;

    int errors = 0;
    int checks = 0;
    int wr_count = 0;
    logic [AW-1:0] exp_addr = '0;
    wr_t sb[$];
    logic [7:0] img [0:MEM_BYTES-1];

    imem_fetch_ctrl #(
        .MEM_BYTES (MEM_BYTES),
        .RESET_PC  (RESET_PC),
        .AW        (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .mem_we      (mem_we),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .pc          (pc),
        .fetch_valid (fetch_valid),
        .stall       (stall),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .done        (done),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Write monitor: pop expected writes when the DUT writes; push when a byte is handed over.
    always @(negedge clk) begin
        wr_t e;
        if (mem_we) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: addr=%0d data=%02h, no write expected", mem_waddr, mem_wdata);
            end else begin
                e = sb.pop_front();
                if (mem_waddr !== e.addr || mem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL wr_order: got addr=%0d data=%02h, want addr=%0d data=%02h",
                             mem_waddr, mem_wdata, e.addr, e.data);
                end
            end
            wr_count++;
        end
        if (reset && ld_valid && ld_ready) begin
            e.addr = exp_addr;
            e.data = ld_data;
            sb.push_back(e);
            exp_addr++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ld_valid = 1'b0; ld_last = 1'b0; stall = 1'b0; redir_valid = 1'b0;
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
        sb.delete();
        exp_addr = '0;
        wr_count = 0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int t;
        t = 0;
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        @(negedge clk);
        while (!ld_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!ld_ready) begin
            checks++; errors++;
            $display("FAIL ld_timeout: ld_ready=%0b, want 1 within 20 cycles", ld_ready);
        end
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic load_bytes(input int n, input logic use_last, input logic gap);
        for (int i = 0; i < n; i++) begin
            send_byte(img[i], use_last && (i == n - 1));
            if (gap && i != n - 1) step();
        end
    endtask

    task automatic enter_run();
        do_reset();
        load_bytes(16, 1'b1, 1'b0);
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        checks++;
        if ({ld_ready, mem_we, fetch_valid, done, fault} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags: rdy/we/fv/done/fault=%05b, want 10000",
                     {ld_ready, mem_we, fetch_valid, done, fault});
        end
        checks++;
        if (pc !== AW'(RESET_PC) || mem_waddr !== '0 || mem_wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_regs: pc=%0d waddr=%0d wdata=%02h, want 0 0 00", pc, mem_waddr, mem_wdata);
        end
        reset = 1'b1;
    endtask

    task automatic test_load_run();
        do_reset();
        load_bytes(16, 1'b1, 1'b0);
        checks++;
        if (fetch_valid !== 1'b0 || mem_we !== 1'b1 || ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL lflush: fv=%0b we=%0b rdy=%0b, want 0 1 0", fetch_valid, mem_we, ld_ready);
        end
        step();
        checks++;
        if (fetch_valid !== 1'b1 || pc !== 32'd0) begin
            errors++;
            $display("FAIL first_fetch: fv=%0b pc=%0d, want 1 0", fetch_valid, pc);
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++;
            if (fetch_valid !== 1'b1 || pc !== AW'(4 * k)) begin
                errors++;
                $display("FAIL seq_pc: fv=%0b pc=%0d, want 1 %0d", fetch_valid, pc, 4 * k);
            end
        end
        step();
        checks++;
        if (done !== 1'b1 || pc !== 32'd12 || fetch_valid !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL seq_done: done=%0b pc=%0d fv=%0b fault=%0b, want 1 12 0 0", done, pc, fetch_valid, fault);
        end
        checks++;
        if (wr_count !== 16 || sb.size() !== 0) begin
            errors++;
            $display("FAIL load16_count: writes=%0d pending=%0d, want 16 0", wr_count, sb.size());
        end
    endtask

    task automatic test_toggle_load();
        int t;
        do_reset();
        load_bytes(16, 1'b1, 1'b1);
        t = 0;
        while (!done && t < 50) begin
            step();
            t++;
        end
        checks++;
        if (done !== 1'b1 || pc !== 32'd12) begin
            errors++;
            $display("FAIL toggle_done: done=%0b pc=%0d, want 1 12", done, pc);
        end
        checks++;
        if (wr_count !== 16 || sb.size() !== 0) begin
            errors++;
            $display("FAIL toggle_count: writes=%0d pending=%0d, want 16 0", wr_count, sb.size());
        end
    endtask

    task automatic test_short_load();
        int fv_seen;
        do_reset();
        load_bytes(6, 1'b1, 1'b0);
        fv_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (fetch_valid) fv_seen++;
            step();
        end
        checks++;
        if (fv_seen != 0 || fault !== 1'b1 || ld_ready !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL short_fault: fv_cycles=%0d fault=%0b rdy=%0b we=%0b, want 0 1 0 0",
                     fv_seen, fault, ld_ready, mem_we);
        end
    endtask

    task automatic test_stall_redirect();
        enter_run();
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (pc !== 32'd4 || fetch_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold: pc=%0d fv=%0b, want 4 1", pc, fetch_valid);
            end
        end
        redir_valid = 1'b1; redir_pc = 32'd0;
        step();
        redir_valid = 1'b0; stall = 1'b0;
        checks++;
        if (pc !== 32'd0 || fetch_valid !== 1'b1) begin
            errors++;
            $display("FAIL redir_over_stall: pc=%0d fv=%0b, want 0 1", pc, fetch_valid);
        end
    endtask

    task automatic test_redirect_bounds();
        logic [AW-1:0] bad [2];
        bad[0] = 32'd16;
        bad[1] = 32'd6;
        for (int i = 0; i < 2; i++) begin
            enter_run();
            redir_valid = 1'b1; redir_pc = bad[i];
            step();
            redir_valid = 1'b0;
            checks++;
            if (fault !== 1'b1 || fetch_valid !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL redir_bad: target=%0d fault=%0b fv=%0b done=%0b, want 1 0 0",
                         bad[i], fault, fetch_valid, done);
            end
        end
        enter_run();
        redir_valid = 1'b1; redir_pc = 32'd12;
        step();
        redir_valid = 1'b0;
        checks++;
        if (pc !== 32'd12 || fetch_valid !== 1'b1) begin
            errors++;
            $display("FAIL redir_12: pc=%0d fv=%0b, want 12 1", pc, fetch_valid);
        end
        step();
        checks++;
        if (done !== 1'b1 || pc !== 32'd12 || fault !== 1'b0) begin
            errors++;
            $display("FAIL redir_12_done: done=%0b pc=%0d fault=%0b, want 1 12 0", done, pc, fault);
        end
    endtask

    task automatic test_full_load_reset();
        do_reset();
        load_bytes(MEM_BYTES, 1'b0, 1'b0);
        checks++;
        if (ld_ready !== 1'b0 || mem_we !== 1'b1 || mem_waddr !== AW'(MEM_BYTES - 1)) begin
            errors++;
            $display("FAIL implicit_last: rdy=%0b we=%0b waddr=%0d, want 0 1 %0d",
                     ld_ready, mem_we, mem_waddr, MEM_BYTES - 1);
        end
        step();
        step();
        step();
        checks++;
        if (fetch_valid !== 1'b1 || pc !== 32'd8 || wr_count !== MEM_BYTES) begin
            errors++;
            $display("FAIL full_run: fv=%0b pc=%0d writes=%0d, want 1 8 %0d", fetch_valid, pc, wr_count, MEM_BYTES);
        end
        reset = 1'b0;
        step();
        checks++;
        if ({ld_ready, mem_we, fetch_valid, done, fault} !== 5'b10000 ||
            pc !== AW'(RESET_PC) || mem_waddr !== '0 || mem_wdata !== 8'h00) begin
            errors++;
            $display("FAIL midrun_reset: rdy/we/fv/done/fault=%05b pc=%0d waddr=%0d wdata=%02h, want 10000 0 0 00",
                     {ld_ready, mem_we, fetch_valid, done, fault}, pc, mem_waddr, mem_wdata);
        end
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] prog [16];
        prog = '{8'h33, 8'h83, 8'h49, 8'h01, 8'h33, 8'h84, 8'h20, 8'h40,
                 8'hb3, 8'h03, 8'h53, 8'h02, 8'h93, 8'h00, 8'h21, 8'h00};
        for (int i = 0; i < MEM_BYTES; i++) begin
            img[i] = (i < 16) ? prog[i] : 8'($urandom_range(0, 255));
        end
        test_reset();
        test_load_run();
        test_toggle_load();
        test_short_load();
        test_stall_redirect();
        test_redirect_bounds();
        test_full_load_reset();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
